// File: rtl/clock_divider_multi_if.sv
// rtl/clock_divider_multi_if.sv - divide-value register-write port of clock_divider_multi
interface clock_divider_multi_if #(
    parameter int SEL_W = 3,
    parameter int CNT_W = 24
);
    logic             cfg_we_i;
    logic [SEL_W-1:0] cfg_sel_i;
    logic [CNT_W-1:0] cfg_div_i;
    logic             cfg_ack_o;
    logic             cfg_err_o;

    modport master (
        output cfg_we_i,
        output cfg_sel_i,
        output cfg_div_i,
        input  cfg_ack_o,
        input  cfg_err_o
    );

    modport slave (
        input  cfg_we_i,
        input  cfg_sel_i,
        input  cfg_div_i,
        output cfg_ack_o,
        output cfg_err_o
    );
endinterface

// File: rtl/clock_divider_multi.sv
// rtl/clock_divider_multi.sv - multi-channel clock divider / tick generator with runtime divide values
// Optional macro CLKDIV_SHADOW_EN: writes are staged and applied at the channel's period boundary.
module clock_divider_multi #(
    parameter int CHANNELS    = 4,
    parameter int CNT_W       = 24,
    parameter int SEL_W       = 3,
    parameter int DEFAULT_DIV = 12000000
) (
    input  logic                clock_test,
    input  logic                rstn,
    input  logic [CHANNELS-1:0] en_i,
    clock_divider_multi_if.slave cfg,
    output logic [CHANNELS-1:0] clock_div_o,
    output logic [CHANNELS-1:0] tick_o
);
    localparam logic [CNT_W-1:0] DIV_RST  = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] DIV_MIN  = CNT_W'(2);
    localparam logic [SEL_W:0]   CH_LIMIT = (SEL_W+1)'(CHANNELS);

    logic sel_bad;
    logic ack_r;
    logic err_r;

    // Extra top bit keeps the range check meaningful when CHANNELS == 2**SEL_W.
    assign sel_bad = ({1'b0, cfg.cfg_sel_i} >= CH_LIMIT);

    always_ff @(posedge clock_test) begin
        if (!rstn) begin
            ack_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            ack_r <= cfg.cfg_we_i;
            err_r <= cfg.cfg_we_i && sel_bad;
        end
    end

    assign cfg.cfg_ack_o = ack_r;
    assign cfg.cfg_err_o = err_r;

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        localparam logic [SEL_W-1:0] CH_ID = SEL_W'(n);

        logic [CNT_W-1:0] div_a;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] eff;
        logic [CNT_W-1:0] last;
        logic [CNT_W-1:0] half;
        logic             clk_r;
        logic             tick_r;
        logic             wr_hit;
        logic             wrap;

        // Stored value is kept as written; D of 0 or 1 is only clamped here.
        assign eff    = (div_a < DIV_MIN) ? DIV_MIN : div_a;
        assign last   = eff - CNT_W'(1);
        assign half   = eff >> 1;
        assign wr_hit = cfg.cfg_we_i && (cfg.cfg_sel_i == CH_ID);
        assign wrap   = en_i[n] && (cnt == last);

        always_ff @(posedge clock_test) begin
            if (!rstn) begin
                cnt    <= '0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
`ifndef CLKDIV_SHADOW_EN
            end else if (wr_hit) begin
                cnt    <= '0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
`endif
            end else if (!en_i[n]) begin
                cnt    <= '0;
                clk_r  <= 1'b0;
                tick_r <= 1'b0;
            end else begin
                tick_r <= wrap;
                clk_r  <= (cnt >= half);
                cnt    <= wrap ? '0 : cnt + CNT_W'(1);
            end
        end

`ifdef CLKDIV_SHADOW_EN
        logic [CNT_W-1:0] div_p;
        logic             pend_v;

        // A copy and a new write on the same edge: the old pending value lands, the new one waits.
        always_ff @(posedge clock_test) begin
            if (!rstn) begin
                div_a  <= DIV_RST;
                div_p  <= '0;
                pend_v <= 1'b0;
            end else begin
                if (pend_v && (wrap || !en_i[n])) begin
                    div_a  <= div_p;
                    pend_v <= 1'b0;
                end
                if (wr_hit) begin
                    div_p  <= cfg.cfg_div_i;
                    pend_v <= 1'b1;
                end
            end
        end
`else
        always_ff @(posedge clock_test) begin
            if (!rstn) begin
                div_a <= DIV_RST;
            end else if (wr_hit) begin
                div_a <= cfg.cfg_div_i;
            end
        end
`endif

        assign clock_div_o[n] = clk_r;
        assign tick_o[n]      = tick_r;
    end
endmodule

// File: tb/tb_clock_divider_multi.sv
// tb/tb_clock_divider_multi.sv - self-checking bench for clock_divider_multi against a cycle-level reference model
module tb_clock_divider_multi;
    localparam int CH  = 4;
    localparam int CW  = 24;
    localparam int SW  = 3;
    localparam int DEF = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rstn;
    logic [CH-1:0] en;
    logic [CH-1:0] cdiv;
    logic [CH-1:0] tick;

    clock_divider_multi_if #(.SEL_W(SW), .CNT_W(CW)) bus ();

    clock_divider_multi #(
        .CHANNELS(CH), .CNT_W(CW), .SEL_W(SW), .DEFAULT_DIV(DEF)
    ) dut (
        .clock_test (clk),
        .rstn       (rstn),
        .en_i       (en),
        .cfg        (bus.slave),
        .clock_div_o(cdiv),
        .tick_o     (tick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int            m_div  [CH];
    int            m_pos  [CH];
    int            m_pend [CH];
    bit            m_pv   [CH];
    logic [CH-1:0] x_clk;
    logic [CH-1:0] x_tick;
    logic          x_ack;
    logic          x_err;

    // Advance one clock: model consumes the inputs seen at the rising edge, then wait for the falling edge.
    task automatic step();
        int  e;
        bit  hit;
        bit  wrap;
        @(posedge clk);
        if (!rstn) begin
            for (int n = 0; n < CH; n++) begin
                m_div[n] = DEF; m_pos[n] = 0; m_pend[n] = 0; m_pv[n] = 0;
            end
            x_clk = '0; x_tick = '0; x_ack = 1'b0; x_err = 1'b0;
        end else begin
            x_ack = bus.cfg_we_i;
            x_err = bus.cfg_we_i && (int'(bus.cfg_sel_i) >= CH);
            for (int n = 0; n < CH; n++) begin
                e    = (m_div[n] < 2) ? 2 : m_div[n];
                hit  = bus.cfg_we_i && (int'(bus.cfg_sel_i) == n);
                wrap = 1'b0;
`ifndef CLKDIV_SHADOW_EN
                if (hit) begin
                    m_div[n] = int'(bus.cfg_div_i); m_pos[n] = 0;
                    x_clk[n] = 1'b0; x_tick[n] = 1'b0;
                    continue;
                end
`endif
                if (!en[n]) begin
                    m_pos[n] = 0; x_clk[n] = 1'b0; x_tick[n] = 1'b0;
                end else begin
                    x_tick[n] = (m_pos[n] == e - 1);
                    x_clk[n]  = (m_pos[n] >= e / 2);
                    wrap      = x_tick[n];
                    m_pos[n]  = wrap ? 0 : m_pos[n] + 1;
                end
`ifdef CLKDIV_SHADOW_EN
                if (m_pv[n] && (wrap || !en[n])) begin
                    m_div[n] = m_pend[n]; m_pv[n] = 1'b0;
                end
                if (hit) begin
                    m_pend[n] = int'(bus.cfg_div_i); m_pv[n] = 1'b1;
                end
`endif
            end
        end
        @(negedge clk);
    endtask

    task automatic cfg_write(input int sel, input int d);
        bus.cfg_we_i  = 1'b1;
        bus.cfg_sel_i = SW'(sel);
        bus.cfg_div_i = CW'(d);
        step();
        bus.cfg_we_i  = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        n_cmp++;
        if ({tick, cdiv, bus.cfg_ack_o, bus.cfg_err_o} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got tick=%b clk=%b ack=%b err=%b want all 0",
                     tick, cdiv, bus.cfg_ack_o, bus.cfg_err_o);
        end
    endtask

    task automatic test_default_pattern();
        logic [CH-1:0] et;
        logic [CH-1:0] ec;
        en   = '1;
        rstn = 1'b1;
        for (int c = 2; c <= 14; c++) begin
            step();
            et = (c >= 5 && c % 4 == 1) ? '1 : '0;
            ec = ((c - 2) % 4 >= 2) ? '1 : '0;
            n_cmp++;
            if (tick !== et || cdiv !== ec) begin
                n_bad++;
                $display("FAIL default_cycle%0d: got tick=%b clk=%b want tick=%b clk=%b", c, tick, cdiv, et, ec);
            end
            n_cmp++;
            if ({tick, cdiv} !== {x_tick, x_clk}) begin
                n_bad++;
                $display("FAIL default_model%0d: got tick=%b clk=%b want tick=%b clk=%b", c, tick, cdiv, x_tick, x_clk);
            end
        end
    endtask

    task automatic test_write_d5();
        int last_t = -1;
        int gap    = 0;
        cfg_write(1, 5);
        n_cmp++;
        if (bus.cfg_ack_o !== 1'b1 || bus.cfg_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL d5_ack: got ack=%b err=%b want ack=1 err=0", bus.cfg_ack_o, bus.cfg_err_o);
        end
        for (int c = 0; c < 24; c++) begin
            step();
            if (tick[1]) begin
                if (last_t >= 0) gap = c - last_t;
                last_t = c;
            end
            n_cmp++;
            if ({tick, cdiv, bus.cfg_ack_o, bus.cfg_err_o} !== {x_tick, x_clk, x_ack, x_err}) begin
                n_bad++;
                $display("FAIL d5_model%0d: got %b/%b/%b%b want %b/%b/%b%b", c, tick, cdiv,
                         bus.cfg_ack_o, bus.cfg_err_o, x_tick, x_clk, x_ack, x_err);
            end
        end
        n_cmp++;
        if (gap !== 5) begin
            n_bad++;
            $display("FAIL d5_period: got %0d want 5", gap);
        end
    endtask

    task automatic test_clamp();
        int d_vals [2] = '{0, 1};
        int last_t;
        int gap;
        for (int k = 0; k < 2; k++) begin
            last_t = -1;
            gap    = 0;
            cfg_write(0, d_vals[k]);
            for (int c = 0; c < 12; c++) begin
                step();
                if (tick[0]) begin
                    if (last_t >= 0) gap = c - last_t;
                    last_t = c;
                end
                n_cmp++;
                if ({tick, cdiv} !== {x_tick, x_clk}) begin
                    n_bad++;
                    $display("FAIL clamp_d%0d_model%0d: got tick=%b clk=%b want tick=%b clk=%b",
                             d_vals[k], c, tick, cdiv, x_tick, x_clk);
                end
            end
            n_cmp++;
            if (gap !== 2) begin
                n_bad++;
                $display("FAIL clamp_d%0d_period: got %0d want 2", d_vals[k], gap);
            end
        end
    endtask

    task automatic test_mid_period();
        int  guard = 0;
        cfg_write(3, 8);
        while (!(m_pos[3] == 2 && m_div[3] == 8 && !m_pv[3]) && guard < 60) begin
            step();
            guard++;
            n_cmp++;
            if ({tick, cdiv} !== {x_tick, x_clk}) begin
                n_bad++;
                $display("FAIL mid_settle%0d: got tick=%b clk=%b want tick=%b clk=%b", guard, tick, cdiv, x_tick, x_clk);
            end
        end
        n_cmp++;
        if (guard >= 60) begin
            n_bad++;
            $display("FAIL mid_reach_cnt2: got no cnt=2 at D=8 within %0d cycles want reached", guard);
        end
        cfg_write(3, 3);
        for (int c = 0; c < 24; c++) begin
            step();
            n_cmp++;
            if ({tick, cdiv} !== {x_tick, x_clk}) begin
                n_bad++;
                $display("FAIL mid_model%0d: got tick=%b clk=%b want tick=%b clk=%b", c, tick, cdiv, x_tick, x_clk);
            end
        end
    endtask

    task automatic test_bad_sel();
        cfg_write(5, 7);
        n_cmp++;
        if (bus.cfg_ack_o !== 1'b1 || bus.cfg_err_o !== 1'b1) begin
            n_bad++;
            $display("FAIL badsel_flags: got ack=%b err=%b want ack=1 err=1", bus.cfg_ack_o, bus.cfg_err_o);
        end
        step();
        n_cmp++;
        if (bus.cfg_ack_o !== 1'b0 || bus.cfg_err_o !== 1'b0) begin
            n_bad++;
            $display("FAIL badsel_clear: got ack=%b err=%b want ack=0 err=0", bus.cfg_ack_o, bus.cfg_err_o);
        end
        for (int c = 0; c < 16; c++) begin
            step();
            n_cmp++;
            if ({tick, cdiv} !== {x_tick, x_clk}) begin
                n_bad++;
                $display("FAIL badsel_model%0d: got tick=%b clk=%b want tick=%b clk=%b", c, tick, cdiv, x_tick, x_clk);
            end
        end
    endtask

    task automatic test_disable_reset();
        step();
        step();
        en[2] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            n_cmp++;
            if (tick[2] !== 1'b0 || cdiv[2] !== 1'b0) begin
                n_bad++;
                $display("FAIL dis_zero%0d: got tick=%b clk=%b want 0 0", c, tick[2], cdiv[2]);
            end
        end
        en[2] = 1'b1;
        for (int c = 0; c < 14; c++) begin
            step();
            n_cmp++;
            if ({tick, cdiv} !== {x_tick, x_clk}) begin
                n_bad++;
                $display("FAIL reen_model%0d: got tick=%b clk=%b want tick=%b clk=%b", c, tick, cdiv, x_tick, x_clk);
            end
        end
        rstn = 1'b0;
        cfg_write(1, 9);
        n_cmp++;
        if ({tick, cdiv, bus.cfg_ack_o} !== '0) begin
            n_bad++;
            $display("FAIL midrst_zero: got tick=%b clk=%b ack=%b want all 0", tick, cdiv, bus.cfg_ack_o);
        end
        rstn = 1'b1;
        for (int c = 2; c <= 14; c++) begin
            step();
            n_cmp++;
            if (tick !== ((c >= 5 && c % 4 == 1) ? '1 : '0) || {tick, cdiv} !== {x_tick, x_clk}) begin
                n_bad++;
                $display("FAIL postrst_cycle%0d: got tick=%b clk=%b want tick=%b clk=%b", c, tick, cdiv, x_tick, x_clk);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            bus.cfg_we_i  = ($urandom_range(0, 3) == 0);
            bus.cfg_sel_i = SW'($urandom_range(0, 7));
            bus.cfg_div_i = CW'($urandom_range(0, 9));
            for (int n = 0; n < CH; n++)
                if ($urandom_range(0, 15) == 0) en[n] = ~en[n];
            step();
            n_cmp++;
            if ({tick, cdiv, bus.cfg_ack_o, bus.cfg_err_o} !== {x_tick, x_clk, x_ack, x_err}) begin
                n_bad++;
                $display("FAIL rand_model%0d: got %b/%b/%b%b want %b/%b/%b%b", c, tick, cdiv,
                         bus.cfg_ack_o, bus.cfg_err_o, x_tick, x_clk, x_ack, x_err);
            end
        end
        bus.cfg_we_i = 1'b0;
    endtask

    initial begin
        rstn          = 1'b0;
        en            = '0;
        bus.cfg_we_i  = 1'b0;
        bus.cfg_sel_i = '0;
        bus.cfg_div_i = '0;
        test_reset();
        test_default_pattern();
        test_write_d5();
        test_clamp();
        test_mid_period();
        test_bad_sel();
        test_disable_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/clock_divider_multi.md
# clock_divider_multi

Parametrised multi-channel clock divider / tick generator, the successor to the single fixed-ratio `clock_division` block. It derives up to `CHANNELS` independent divided clocks and single-cycle tick strobes from the board clock (12 MHz X1 or the internal OSCH). Each channel's ratio is set at runtime through a register-write port. Downstream timing logic (dispense timers, debounce, display refresh) consumes these outputs.

## Interface
- `CHANNELS`, 4: number of divider channels, 1..8.
- `CNT_W`, 24: counter and divide-value width.
- `SEL_W`, 3: channel-select width; must satisfy 2^SEL_W ≥ CHANNELS.
- `DEFAULT_DIV`, 12000000: divide value loaded into every channel at reset (1 s at 12 MHz).

- `clock_test` in 1: sole clock; all logic on its rising edge.
- `rstn` in 1: reset, synchronous, active-low.
- `en_i` in CHANNELS: per-channel run enable.
- `cfg_we_i` in 1: single-cycle divide-value write strobe.
- `cfg_sel_i` in SEL_W: target channel for the write.
- `cfg_div_i` in CNT_W: new divide value D.
- `cfg_ack_o` out 1: one-cycle acknowledge of a write.
- `cfg_err_o` out 1: one-cycle error flag; `cfg_sel_i` ≥ CHANNELS.
- `clock_div_o` out CHANNELS: divided clock per channel, period D.
- `tick_o` out CHANNELS: one-cycle strobe per period per channel.

## Operation
- Per channel:
  - active divide register `div_a`
  - counter `cnt`, CNT_W wide
  - output registers `clk_r` and `tick_r`
- Effective divide value is E = max(D, 2). D = 0 and D = 1 are clamped to 2. The stored value is D unmodified; the clamp is applied at use.
- Enabled channel behaviour:
  - `cnt` counts 0..E-1, then wraps to 0.
  - `tick_r` ← (`cnt` == E-1).
  - `clk_r` ← (`cnt` ≥ E>>1). Low for floor(E/2) cycles, high for ceil(E/2) cycles; odd E gives the longer high phase.
- Disabled channel (`en_i[n]`=0):
  - `cnt` is held at 0; `clk_r` and `tick_r` are forced to 0 on the next edge.
  - On re-enable, counting restarts from 0. No partial period is emitted.
- Config write:
  - When `cfg_we_i`=1, the next edge registers `cfg_ack_o`=1.
  - A valid `cfg_sel_i` updates that channel per the Configuration section.
  - An invalid `cfg_sel_i` updates nothing, and `cfg_err_o`=1 together with `cfg_ack_o`.
  - Back-to-back writes on consecutive cycles are all accepted. The last write to the same channel wins.
- Channels are fully independent; there is no phase alignment between channels.

## Timing
- Reset values (`rstn`=0 at an edge):
  - all `cnt`=0, `clk_r`=0, `tick_r`=0
  - `cfg_ack_o`=0, `cfg_err_o`=0
  - `div_a`=`DEFAULT_DIV`; pending registers are cleared and their valid bits are 0
- Reset takes priority over en, writes and counting; a write in the same cycle as reset is lost.
- With `en_i[n]`=1 held from the first cycle after reset release (cycle 1 has `cnt`=0):
  - `tick_o[n]` is high in cycles E+1, 2E+1, …
  - `clock_div_o[n]` rises in cycle (E>>1)+2 of each period, relative to cycle 1 at period start.
- Write latency: `cfg_ack_o`/`cfg_err_o` are high exactly 1 cycle after `cfg_we_i`.
- Outputs are glitch-free registers. Downstream logic must use `tick_o` as an enable, not `clock_div_o` as a clock.

## Configuration
- Macro `CLKDIV_SHADOW_EN`.
- Defined:
  - The write goes to a per-channel pending register with a valid bit.
  - If the channel is enabled, the pending value is copied to `div_a` on the edge where `cnt` wraps E-1→0, so the current period completes with the old value.
  - If the channel is disabled, the copy happens on the next edge.
  - A second write before the copy overwrites the pending value.
- Undefined:
  - `div_a` is updated on the edge following the write, and `cnt` restarts at 0.
  - `clk_r` and `tick_r` are 0 in the cycle after the load. The in-flight period is truncated.
  - No pending registers exist.

## Test plan
- Reset release, all `en_i`=1, `DEFAULT_DIV` overridden to 4 → every `tick_o` high in cycles 5, 9, 13; `clock_div_o` pattern 0,0,1,1 repeating from cycle 2.
- Write D=5 to channel 1 → period 5, `clock_div_o[1]` low 2 cycles / high 3 cycles, `cfg_ack_o` one cycle after the strobe.
- Write D=0, then D=1, to channel 0 → both behave as E=2: `tick_o[0]` every 2nd cycle and `clock_div_o[0]` toggles each cycle.
- Mid-period write of D=3 to a channel running at D=8, with `cnt`=2:
  - `CLKDIV_SHADOW_EN` defined → the current 8-cycle period completes, then 3-cycle periods.
  - Undefined → restart from 0, and the next tick comes 3 cycles after the load.
- Write with `cfg_sel_i`=5 and CHANNELS=4 → `cfg_ack_o`=`cfg_err_o`=1 for one cycle; no channel period changes.
- Drop `en_i[2]` for 3 cycles mid-period, then assert `rstn`=0 for 1 cycle during counting → outputs 0 while disabled and a full fresh period after re-enable; after reset, all `div_a`=`DEFAULT_DIV` and the outputs restart from cycle 1.
